ascon_perm_ctrl: RTL and testbench
==================================

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have inputs reg0_128b, reg1_128b and reg2_128b, each 128 bits: key K, nonce N and data block/tag from the SPI subnode.
REQ-004 SHALL have input operation_mode, 3 bits, the mode code.
REQ-005 SHALL have input operation_ready, 1 bit, a level request held until operation_done.
REQ-006 SHALL have inputs state_shift_en (1), state_shift_sel (3) and state_shift_lsb (1): SPI serial load strobe, target word and data bit.
REQ-007 SHALL have output operation_done, 1 bit, a one-cycle completion pulse.
REQ-008 SHALL have output busy, 1 bit, high whenever the FSM is not in IDLE.
REQ-009 SHALL have outputs reg_128b_wrback_en (1), reg_128b_wrback_sel (2) and reg_128b_wrback_val (128): writeback to the SPI subnode.
REQ-010 SHALL have outputs S_0_reg to S_4_reg, 64 bits each, the Ascon state words.

Function
REQ-011 SHALL implement FSM states IDLE, PRE, ROUND, POST and DONE.
REQ-012 IDLE with operation_ready=1: SHALL latch operation_mode and go to PRE; otherwise stay in IDLE.
REQ-013 PRE SHALL apply the mode pre-action, then go to ROUND if the round count is nonzero, else to POST.
REQ-014 ROUND SHALL apply one Ascon round per cycle, in order: constant addition, 5-bit S-box, linear layer.
REQ-015 Round index i SHALL run from (12-N) to 11, with constant c = ((15-i)<<4)|i XORed into S_2_reg; ROUND goes to POST after the N-th round.
REQ-016 POST SHALL apply the mode post-action and go to DONE.
REQ-017 DONE SHALL drive operation_done=1 for exactly one cycle, then return to IDLE.
REQ-018 Latency: with acceptance at edge E0, operation_done SHALL be high in the cycle following edge E0+N+2.
REQ-019 IDLE SHALL NOT re-accept in the DONE cycle; the subnode clears ready at that edge, so a still-high operation_ready is not a second request.
REQ-020 Mode 000 NOP: N=0, no actions.
REQ-021 Mode 001 INIT: PRE loads S0=IV 0x80400c0600000000, {S1,S2}=K, {S3,S4}=N; N=12; POST does {S3,S4}^=K.
REQ-022 Mode 010 ABSORB: PRE does S0^=reg2[127:64]; N=6; no post-action.
REQ-023 Mode 011 DOMSEP: N=0; PRE does S4^=1.
REQ-024 Mode 100 ENCRYPT: PRE does S0^=reg2[127:64]; POST writes back {S0, reg2[63:0]} with sel=2'b10; N=6.
REQ-025 Mode 101 ENC_LAST: same as ENCRYPT but N=0.
REQ-026 Mode 110 FINAL: PRE does {S1,S2}^=K; N=12; POST does {S3,S4}^=K, then writes back {S3,S4} to reg2.
REQ-027 Mode 111 PERM12: N=12, no pre- or post-actions.
REQ-028 In ENCRYPT, ENC_LAST and FINAL, POST SHALL pulse reg_128b_wrback_en for one cycle; in all other cycles it SHALL be 0.
REQ-029 In IDLE only, state_shift_en=1 SHALL shift the word selected by state_shift_sel left by one bit, with state_shift_lsb entering bit 0.
REQ-030 state_shift_sel values 5-7 SHALL be ignored, and state_shift_en SHALL be ignored when busy.
REQ-031 A mode request and a state_shift_en in the same IDLE cycle: the shift SHALL apply and the request SHALL be accepted.
REQ-032 reg0_128b, reg1_128b and reg2_128b SHALL be read live; host writes while busy are a protocol violation with undefined results.

Reset
REQ-033 rst=1 at any clock edge, including mid-operation, SHALL force IDLE, all S_x_reg=0, operation_done=0, reg_128b_wrback_en=0, reg_128b_wrback_sel=0, reg_128b_wrback_val=0, the latched mode to 0 and the round counter to 0.
REQ-034 No operation SHALL resume after reset.

Structure
REQ-035 Package ascon_pkg SHALL hold the mode encodings, IV, round count per mode, FSM state encoding and writeback select codes.
REQ-036 Sub-module ascon_round SHALL be a purely combinational single round: inputs 320-bit state and 4-bit index, output 320-bit state.

Verification
REQ-037 Reset mid-ROUND of INIT -> next cycle busy=0, all S_x_reg=0, no operation_done pulse.
REQ-038 K=N=000102..0f: run INIT, DOMSEP, then ENC_LAST with reg2=0x80 followed by 120 zero bits, then FINAL -> final writeback value e355159f292911f794cb1432a0103a8a.
REQ-039 PERM12 from the all-zero state, one request -> operation_done exactly 14 cycles after the acceptance edge, and exactly one pulse even with operation_ready held high 3 extra cycles.
REQ-040 Serial shift of 64 bits 0x0123456789abcdef into sel=3 -> S_3_reg=0x0123456789abcdef; the same shifts while busy -> S_3_reg unchanged.
REQ-041 NOP and DOMSEP -> operation_done 2 cycles after acceptance; DOMSEP toggles S_4_reg bit 0 only; no writeback pulse.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared constants, state layout and helpers for the Ascon permutation controller.
package ascon_pkg;

    localparam int unsigned WORD_W   = 64;
    localparam int unsigned STATE_W  = 5 * WORD_W;
    localparam int unsigned BLK_W    = 128;
    localparam int unsigned MODE_W   = 3;
    localparam int unsigned RND_W    = 4;
    localparam int unsigned FSM_W    = 3;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned WB_SEL_W = 2;

    localparam logic [MODE_W-1:0] MODE_NOP      = 3'b000;
    localparam logic [MODE_W-1:0] MODE_INIT     = 3'b001;
    localparam logic [MODE_W-1:0] MODE_ABSORB   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_DOMSEP   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ENCRYPT  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ENC_LAST = 3'b101;
    localparam logic [MODE_W-1:0] MODE_FINAL    = 3'b110;
    localparam logic [MODE_W-1:0] MODE_PERM12   = 3'b111;

    localparam logic [WORD_W-1:0] ASCON_IV = 64'h80400c0600000000;

    localparam logic [RND_W-1:0] ROUNDS_FULL  = 4'd12;
    localparam logic [RND_W-1:0] ROUNDS_HALF  = 4'd6;
    localparam logic [RND_W-1:0] LAST_RND_IDX = 4'd11;

    localparam logic [FSM_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [FSM_W-1:0] ST_PRE   = 3'd1;
    localparam logic [FSM_W-1:0] ST_ROUND = 3'd2;
    localparam logic [FSM_W-1:0] ST_POST  = 3'd3;
    localparam logic [FSM_W-1:0] ST_DONE  = 3'd4;

    localparam logic [WB_SEL_W-1:0] WB_SEL_NONE = 2'b00;
    localparam logic [WB_SEL_W-1:0] WB_SEL_REG2 = 2'b10;

    // x0 occupies the most significant word of the packed 320-bit state
    typedef struct packed {
        logic [WORD_W-1:0] x0;
        logic [WORD_W-1:0] x1;
        logic [WORD_W-1:0] x2;
        logic [WORD_W-1:0] x3;
        logic [WORD_W-1:0] x4;
    } ascon_state_t;

    function automatic logic [RND_W-1:0] mode_rounds(input logic [MODE_W-1:0] mode);
        logic [RND_W-1:0] r;
        case (mode)
            MODE_INIT, MODE_FINAL, MODE_PERM12:     r = ROUNDS_FULL;
            MODE_ABSORB, MODE_ENCRYPT:              r = ROUNDS_HALF;
            MODE_NOP, MODE_DOMSEP, MODE_ENC_LAST:   r = '0;
            default:                                r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [RND_W-1:0]   rnd_idx,
    output logic [STATE_W-1:0] state_out
);

    ascon_state_t      s_in;
    logic [7:0]        rc;
    logic [WORD_W-1:0] a0, a1, a2, a3, a4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    logic [WORD_W-1:0] b0, b1, b2, b3, b4;
    logic [WORD_W-1:0] c0, c1, c2, c3, c4;
    logic [WORD_W-1:0] d0, d1, d2, d3, d4;

    assign s_in = ascon_state_t'(state_in);
    assign rc   = {4'(4'd15 - rnd_idx), rnd_idx};

    // Round constant folded into the S-box input xor stage
    assign a0 = s_in.x0 ^ s_in.x4;
    assign a1 = s_in.x1;
    assign a2 = s_in.x2 ^ WORD_W'(rc) ^ s_in.x1;
    assign a3 = s_in.x3;
    assign a4 = s_in.x4 ^ s_in.x3;

    assign t0 = ~a0 & a1;
    assign t1 = ~a1 & a2;
    assign t2 = ~a2 & a3;
    assign t3 = ~a3 & a4;
    assign t4 = ~a4 & a0;

    assign b0 = a0 ^ t1;
    assign b1 = a1 ^ t2;
    assign b2 = a2 ^ t3;
    assign b3 = a3 ^ t4;
    assign b4 = a4 ^ t0;

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign d0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    assign d1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    assign d2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
    assign d3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    assign d4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

    assign state_out = {d0, d1, d2, d3, d4};

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation controller: mode pre/post actions around an iterated round,
// serial state load from the SPI subnode, and writeback of ciphertext/tag.
module ascon_perm_ctrl
    import ascon_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BLK_W-1:0]    reg0_128b,
    input  logic [BLK_W-1:0]    reg1_128b,
    input  logic [BLK_W-1:0]    reg2_128b,
    input  logic [MODE_W-1:0]   operation_mode,
    input  logic                operation_ready,
    input  logic                state_shift_en,
    input  logic [SEL_W-1:0]    state_shift_sel,
    input  logic                state_shift_lsb,
    output logic                operation_done,
    output logic                busy,
    output logic                reg_128b_wrback_en,
    output logic [WB_SEL_W-1:0] reg_128b_wrback_sel,
    output logic [BLK_W-1:0]    reg_128b_wrback_val,
    output logic [WORD_W-1:0]   S_0_reg,
    output logic [WORD_W-1:0]   S_1_reg,
    output logic [WORD_W-1:0]   S_2_reg,
    output logic [WORD_W-1:0]   S_3_reg,
    output logic [WORD_W-1:0]   S_4_reg
);

    logic [FSM_W-1:0]    state_q,   state_nxt;
    logic [MODE_W-1:0]   mode_q,    mode_nxt;
    logic [RND_W-1:0]    rnd_q,     rnd_nxt;
    logic                armed_q,   armed_nxt;
    ascon_state_t        s_q,       s_nxt;
    logic                done_q,    done_nxt;
    logic                busy_q,    busy_nxt;
    logic                wb_en_q,   wb_en_nxt;
    logic [WB_SEL_W-1:0] wb_sel_q,  wb_sel_nxt;
    logic [BLK_W-1:0]    wb_val_q,  wb_val_nxt;
    logic [STATE_W-1:0]  round_out;
    logic [RND_W-1:0]    n_rounds;

    ascon_round u_round (
        .state_in  (s_q),
        .rnd_idx   (rnd_q),
        .state_out (round_out)
    );

    assign n_rounds = mode_rounds(mode_q);

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state_q;
        mode_nxt   = mode_q;
        rnd_nxt    = rnd_q;
        s_nxt      = s_q;
        done_nxt   = 1'b0;
        wb_en_nxt  = 1'b0;
        wb_sel_nxt = wb_sel_q;
        wb_val_nxt = wb_val_q;
        // A request is re-armed only after ready has been seen low, so a level
        // left high after completion or across reset never starts a new run.
        armed_nxt  = armed_q | ~operation_ready;

        case (state_q)
            ST_IDLE: begin
                if (state_shift_en) begin
                    case (state_shift_sel)
                        3'd0:    s_nxt.x0 = {s_q.x0[WORD_W-2:0], state_shift_lsb};
                        3'd1:    s_nxt.x1 = {s_q.x1[WORD_W-2:0], state_shift_lsb};
                        3'd2:    s_nxt.x2 = {s_q.x2[WORD_W-2:0], state_shift_lsb};
                        3'd3:    s_nxt.x3 = {s_q.x3[WORD_W-2:0], state_shift_lsb};
                        3'd4:    s_nxt.x4 = {s_q.x4[WORD_W-2:0], state_shift_lsb};
                        default: ;
                    endcase
                end
                if (operation_ready && armed_q) begin
                    mode_nxt  = operation_mode;
                    armed_nxt = 1'b0;
                    state_nxt = ST_PRE;
                end
            end

            ST_PRE: begin
                case (mode_q)
                    MODE_INIT: begin
                        s_nxt.x0 = ASCON_IV;
                        s_nxt.x1 = reg0_128b[BLK_W-1:WORD_W];
                        s_nxt.x2 = reg0_128b[WORD_W-1:0];
                        s_nxt.x3 = reg1_128b[BLK_W-1:WORD_W];
                        s_nxt.x4 = reg1_128b[WORD_W-1:0];
                    end
                    MODE_ABSORB, MODE_ENCRYPT, MODE_ENC_LAST:
                        s_nxt.x0 = s_q.x0 ^ reg2_128b[BLK_W-1:WORD_W];
                    MODE_DOMSEP:
                        s_nxt.x4 = s_q.x4 ^ WORD_W'(1);
                    MODE_FINAL: begin
                        s_nxt.x1 = s_q.x1 ^ reg0_128b[BLK_W-1:WORD_W];
                        s_nxt.x2 = s_q.x2 ^ reg0_128b[WORD_W-1:0];
                    end
                    default: ;
                endcase
                rnd_nxt   = RND_W'(ROUNDS_FULL - n_rounds);
                state_nxt = (n_rounds != '0) ? ST_ROUND : ST_POST;
            end

            ST_ROUND: begin
                s_nxt = ascon_state_t'(round_out);
                if (rnd_q == LAST_RND_IDX) begin
                    state_nxt = ST_POST;
                end else begin
                    rnd_nxt = RND_W'(rnd_q + 4'd1);
                end
            end

            ST_POST: begin
                case (mode_q)
                    MODE_INIT: begin
                        s_nxt.x3 = s_q.x3 ^ reg0_128b[BLK_W-1:WORD_W];
                        s_nxt.x4 = s_q.x4 ^ reg0_128b[WORD_W-1:0];
                    end
                    MODE_ENCRYPT, MODE_ENC_LAST: begin
                        wb_en_nxt  = 1'b1;
                        wb_sel_nxt = WB_SEL_REG2;
                        wb_val_nxt = {s_q.x0, reg2_128b[WORD_W-1:0]};
                    end
                    MODE_FINAL: begin
                        s_nxt.x3   = s_q.x3 ^ reg0_128b[BLK_W-1:WORD_W];
                        s_nxt.x4   = s_q.x4 ^ reg0_128b[WORD_W-1:0];
                        wb_en_nxt  = 1'b1;
                        wb_sel_nxt = WB_SEL_REG2;
                        wb_val_nxt = {s_nxt.x3, s_nxt.x4};
                    end
                    default: ;
                endcase
                done_nxt  = 1'b1;
                state_nxt = ST_DONE;
            end

            ST_DONE: state_nxt = ST_IDLE;

            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            rnd_q    <= '0;
            armed_q  <= 1'b0;
            s_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            wb_en_q  <= 1'b0;
            wb_sel_q <= WB_SEL_NONE;
            wb_val_q <= '0;
        end else begin
            state_q  <= state_nxt;
            mode_q   <= mode_nxt;
            rnd_q    <= rnd_nxt;
            armed_q  <= armed_nxt;
            s_q      <= s_nxt;
            done_q   <= done_nxt;
            busy_q   <= busy_nxt;
            wb_en_q  <= wb_en_nxt;
            wb_sel_q <= wb_sel_nxt;
            wb_val_q <= wb_val_nxt;
        end
    end

    assign operation_done      = done_q;
    assign busy                = busy_q;
    assign reg_128b_wrback_en  = wb_en_q;
    assign reg_128b_wrback_sel = wb_sel_q;
    assign reg_128b_wrback_val = wb_val_q;
    assign S_0_reg             = s_q.x0;
    assign S_1_reg             = s_q.x1;
    assign S_2_reg             = s_q.x2;
    assign S_3_reg             = s_q.x3;
    assign S_4_reg             = s_q.x4;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed + randomized bench for ascon_perm_ctrl against a table-driven
// Ascon reference model (S-box lookup per bit column, explicit rotations).
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] reg0_128b, reg1_128b, reg2_128b;
    logic [2:0]   operation_mode;
    logic         operation_ready;
    logic         state_shift_en;
    logic [2:0]   state_shift_sel;
    logic         state_shift_lsb;
    logic         operation_done;
    logic         busy;
    logic         reg_128b_wrback_en;
    logic [1:0]   reg_128b_wrback_sel;
    logic [127:0] reg_128b_wrback_val;
    logic [63:0]  S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] m [5];

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5]  = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5]  = '{28, 39, 6, 17, 41};
    localparam int NR_TAB [8] = '{0, 12, 6, 0, 6, 0, 12, 12};

    ascon_perm_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .reg0_128b           (reg0_128b),
        .reg1_128b           (reg1_128b),
        .reg2_128b           (reg2_128b),
        .operation_mode      (operation_mode),
        .operation_ready     (operation_ready),
        .state_shift_en      (state_shift_en),
        .state_shift_sel     (state_shift_sel),
        .state_shift_lsb     (state_shift_lsb),
        .operation_done      (operation_done),
        .busy                (busy),
        .reg_128b_wrback_en  (reg_128b_wrback_en),
        .reg_128b_wrback_sel (reg_128b_wrback_sel),
        .reg_128b_wrback_val (reg_128b_wrback_val),
        .S_0_reg             (S_0_reg),
        .S_1_reg             (S_1_reg),
        .S_2_reg             (S_2_reg),
        .S_3_reg             (S_3_reg),
        .S_4_reg             (S_4_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic model_perm(input int nr);
        logic [63:0] y [5];
        logic [4:0]  col, sv;
        for (int r = 12 - nr; r < 12; r++) begin
            m[2] = m[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                col = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
                sv  = SBOX[col];
                for (int w = 0; w < 5; w++) y[w][b] = sv[4 - w];
            end
            for (int w = 0; w < 5; w++) m[w] = y[w] ^ ror(y[w], ROT_A[w]) ^ ror(y[w], ROT_B[w]);
        end
    endtask

    task automatic model_op(input logic [2:0] mode, output bit exp_wb, output logic [127:0] wb);
        exp_wb = 1'b0;
        wb     = '0;
        case (mode)
            3'd1: begin
                m[0] = 64'h80400c0600000000;
                m[1] = reg0_128b[127:64]; m[2] = reg0_128b[63:0];
                m[3] = reg1_128b[127:64]; m[4] = reg1_128b[63:0];
            end
            3'd2, 3'd4, 3'd5: m[0] = m[0] ^ reg2_128b[127:64];
            3'd3: m[4] = m[4] ^ 64'd1;
            3'd6: begin
                m[1] = m[1] ^ reg0_128b[127:64]; m[2] = m[2] ^ reg0_128b[63:0];
            end
            default: ;
        endcase
        model_perm(NR_TAB[mode]);
        case (mode)
            3'd1: begin
                m[3] = m[3] ^ reg0_128b[127:64]; m[4] = m[4] ^ reg0_128b[63:0];
            end
            3'd4, 3'd5: begin
                exp_wb = 1'b1; wb = {m[0], reg2_128b[63:0]};
            end
            3'd6: begin
                m[3] = m[3] ^ reg0_128b[127:64]; m[4] = m[4] ^ reg0_128b[63:0];
                exp_wb = 1'b1; wb = {m[3], m[4]};
            end
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_S0"}, 128'(S_0_reg), 128'(m[0]));
        chk({tag, "_S1"}, 128'(S_1_reg), 128'(m[1]));
        chk({tag, "_S2"}, 128'(S_2_reg), 128'(m[2]));
        chk({tag, "_S3"}, 128'(S_3_reg), 128'(m[3]));
        chk({tag, "_S4"}, 128'(S_4_reg), 128'(m[4]));
    endtask

    // Called just after an active edge; caller may already drive a shift for the accept cycle
    task automatic run_op(input logic [2:0] mode, input int hold, input bit shift_busy);
        int           nr;
        bit           exp_wb;
        logic [127:0] wb;
        nr = NR_TAB[mode];
        model_op(mode, exp_wb, wb);
        operation_mode  = mode;
        operation_ready = 1'b1;
        @(posedge clk); #1;
        state_shift_en = 1'b0;
        chk("accept_busy", 128'(busy), 128'(1'b1));
        for (int c = 1; c <= nr + 2; c++) begin
            if (shift_busy) begin
                state_shift_en  = 1'b1;
                state_shift_sel = 3'd3;
                state_shift_lsb = 1'($urandom);
            end
            @(posedge clk); #1;
            chk("done_timing", 128'(operation_done), 128'(c == nr + 2));
            chk("wb_en_timing", 128'(reg_128b_wrback_en), 128'((c == nr + 2) && exp_wb));
        end
        state_shift_en = 1'b0;
        chk_state("op");
        if (exp_wb) begin
            chk("wb_val", reg_128b_wrback_val, wb);
            chk("wb_sel", 128'(reg_128b_wrback_sel), 128'(2'b10));
        end
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) operation_ready = 1'b0;
            @(posedge clk); #1;
            chk("no_second_done", 128'(operation_done), 128'(1'b0));
            chk("idle_after_done", 128'(busy), 128'(1'b0));
        end
    endtask

    task automatic shift_bit(input logic [2:0] sel, input logic b);
        int idx;
        state_shift_en  = 1'b1;
        state_shift_sel = sel;
        state_shift_lsb = b;
        @(posedge clk); #1;
        state_shift_en = 1'b0;
        idx = int'(sel);
        if (idx < 5) m[idx] = {m[idx][62:0], b};
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int w = 0; w < 5; w++) m[w] = '0;
    endtask

    initial begin
        logic [63:0]  pattern;
        logic [127:0] kn;
        rst = 1'b1;
        reg0_128b = '0; reg1_128b = '0; reg2_128b = '0;
        operation_mode = '0; operation_ready = 1'b0;
        state_shift_en = 1'b0; state_shift_sel = '0; state_shift_lsb = 1'b0;
        for (int w = 0; w < 5; w++) m[w] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(operation_done), 128'(1'b0));
        chk("rst_wb_en", 128'(reg_128b_wrback_en), 128'(1'b0));
        chk_state("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Serial load of a known word, then random shifts including ignored selects
        pattern = 64'h0123456789abcdef;
        for (int i = 63; i >= 0; i--) shift_bit(3'd3, pattern[i]);
        chk("shift_S3", 128'(S_3_reg), 128'(64'h0123456789abcdef));
        for (int i = 0; i < 40; i++) shift_bit(3'($urandom_range(0, 7)), 1'($urandom));
        chk_state("rand_shift");

        run_op(3'd0, 0, 1'b0);
        run_op(3'd3, 0, 1'b0);

        // Shifts presented while busy must leave the state untouched
        run_op(3'd7, 0, 1'b1);

        apply_reset();
        @(posedge clk); #1;
        run_op(3'd7, 3, 1'b0);

        // Ascon-128 known answer: empty AD, empty plaintext
        kn = 128'h000102030405060708090a0b0c0d0e0f;
        reg0_128b = kn; reg1_128b = kn;
        run_op(3'd1, 0, 1'b0);
        run_op(3'd3, 0, 1'b0);
        reg2_128b = {8'h80, 120'd0};
        run_op(3'd5, 0, 1'b0);
        run_op(3'd6, 0, 1'b0);
        chk("kat_tag", reg_128b_wrback_val, 128'he355159f292911f794cb1432a0103a8a);

        // Reset in the middle of INIT rounds
        operation_mode  = 3'd1;
        operation_ready = 1'b1;
        @(posedge clk); #1;
        chk("midrst_accept", 128'(busy), 128'(1'b1));
        repeat (5) @(posedge clk);
        #1;
        apply_reset();
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_done", 128'(operation_done), 128'(1'b0));
        chk("midrst_wb_en", 128'(reg_128b_wrback_en), 128'(1'b0));
        chk("midrst_wb_sel", 128'(reg_128b_wrback_sel), 128'(2'b00));
        chk("midrst_wb_val", reg_128b_wrback_val, 128'd0);
        chk_state("midrst");
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_resume_done", 128'(operation_done), 128'(1'b0));
            chk("midrst_no_resume_busy", 128'(busy), 128'(1'b0));
        end
        operation_ready = 1'b0;
        @(posedge clk); #1;

        // Shift and request in the same idle cycle
        reg2_128b = {$urandom, $urandom, $urandom, $urandom};
        state_shift_en  = 1'b1;
        state_shift_sel = 3'd0;
        state_shift_lsb = 1'b1;
        m[0] = {m[0][62:0], 1'b1};
        run_op(3'd2, 0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            reg0_128b = {$urandom, $urandom, $urandom, $urandom};
            reg1_128b = {$urandom, $urandom, $urandom, $urandom};
            reg2_128b = {$urandom, $urandom, $urandom, $urandom};
            run_op(3'($urandom_range(0, 7)), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
